// File: rtl/cbm2_ramctl.sv
`default_nettype none
// ============================================================================
//  Module   : cbm2_ramctl
//  Purpose  : RAM responder behind the CBM-II bus decoder. Turns decoded
//             CPU/video RAM cycles into single-request transactions on a
//             byte-wide external memory port, and writes HPS download bytes
//             into the same memory between bus cycles.
//  Ports    : clk_sys, reset_n (async, active-low)
//             cpuCycle/vidCycle/cs_ram/systemAddr/systemWe/cpuDo - bus side
//             ramData                                             - read data
//             ioctl_download/ioctl_wr/ioctl_addr/ioctl_data/ioctl_wait
//             mem_req/mem_we/mem_addr/mem_din/mem_dout/mem_ack    - memory
//  Revision : 1.0  initial release
// ============================================================================
module cbm2_ramctl #(
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] LOAD_BASE = ADDR_W'(25'h0F0000)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cpuCycle,
    input  logic              vidCycle,
    input  logic              cs_ram,
    input  logic [ADDR_W-1:0] systemAddr,
    input  logic              systemWe,
    input  logic [7:0]        cpuDo,
    output logic [7:0]        ramData,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [23:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Bus-cycle edge detection
    logic r_cycPrev;
    logic w_cycActive;
    logic w_cycStart;
    logic w_busHit;
    logic w_liveWe;

    // Memory request registers
    logic              r_memReq;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [7:0]        r_memDin;
    logic [7:0]        r_ramData;

    // Single-entry download buffer
    logic              r_bufFull;
    logic [ADDR_W-1:0] r_bufAddr;
    logic [7:0]        r_bufData;
    logic              w_fill;
    logic [ADDR_W-1:0] w_loadAddr;

    // Bus cycle that arrived while a load write was outstanding
    logic              r_pend;
    logic              r_pendWe;
    logic [ADDR_W-1:0] r_pendAddr;
    logic [7:0]        r_pendData;

    // Actions decided by the FSM for this clock
    logic w_issueLive;
    logic w_issuePend;
    logic w_issueLoad;
    logic w_reqDone;
    logic w_rdCapture;
    logic w_capturePend;
    logic w_bufClear;

    assign w_cycActive = cpuCycle | vidCycle;
    assign w_cycStart  = w_cycActive & ~r_cycPrev;
    assign w_busHit    = w_cycStart & cs_ram;
    // Video cycles never write, whatever systemWe says.
    assign w_liveWe    = systemWe & cpuCycle;

    // A byte offered while the buffer is occupied is dropped.
    assign w_fill      = ioctl_wr & ioctl_download & ~r_bufFull;
    assign w_loadAddr  = LOAD_BASE + ADDR_W'(ioctl_addr);

    // w_fill term makes the stall visible in the same clock as the strobe.
    assign ioctl_wait  = r_bufFull | w_fill | (r_state != S_IDLE);

    assign mem_req     = r_memReq;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_din     = r_memDin;
    assign ramData     = r_ramData;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext   = r_state;
        w_issueLive   = 1'b0;
        w_issuePend   = 1'b0;
        w_issueLoad   = 1'b0;
        w_reqDone     = 1'b0;
        w_rdCapture   = 1'b0;
        w_capturePend = 1'b0;
        w_bufClear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Bus has priority over a waiting load byte.
                if (w_busHit) begin
                    w_issueLive = 1'b1;
                    w_stateNext = S_BUS;
                end else if (r_bufFull && !w_cycActive) begin
                    w_issueLoad = 1'b1;
                    w_stateNext = S_LOAD;
                end
            end
            S_BUS: begin
                if (mem_ack) begin
                    w_reqDone   = 1'b1;
                    w_rdCapture = ~r_memWe;
                    w_stateNext = S_IDLE;
                end
            end
            S_LOAD: begin
                if (mem_ack) begin
                    w_bufClear = 1'b1;
                    w_reqDone  = 1'b1;
                    // A waiting bus access goes straight out; the request
                    // line then carries the bus transaction next clock.
                    if (r_pend) begin
                        w_issuePend = 1'b1;
                        w_stateNext = S_BUS;
                    end else if (w_busHit) begin
                        w_issueLive = 1'b1;
                        w_stateNext = S_BUS;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else if (w_busHit) begin
                    w_capturePend = 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cycPrev  <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memDin   <= 8'h00;
            r_ramData  <= 8'h00;
            r_bufFull  <= 1'b0;
            r_bufAddr  <= '0;
            r_bufData  <= 8'h00;
            r_pend     <= 1'b0;
            r_pendWe   <= 1'b0;
            r_pendAddr <= '0;
            r_pendData <= 8'h00;
        end else begin
            r_cycPrev <= w_cycActive;

            // Request fields only change when a new request is issued,
            // so they stay stable for as long as mem_req is high.
            if (w_issueLive) begin
                r_memReq  <= 1'b1;
                r_memWe   <= w_liveWe;
                r_memAddr <= systemAddr;
                r_memDin  <= cpuDo;
            end else if (w_issuePend) begin
                r_memReq  <= 1'b1;
                r_memWe   <= r_pendWe;
                r_memAddr <= r_pendAddr;
                r_memDin  <= r_pendData;
            end else if (w_issueLoad) begin
                r_memReq  <= 1'b1;
                r_memWe   <= 1'b1;
                r_memAddr <= r_bufAddr;
                r_memDin  <= r_bufData;
            end else if (w_reqDone) begin
                r_memReq  <= 1'b0;
            end

            if (w_rdCapture) begin
                r_ramData <= mem_dout;
            end

            if (w_capturePend) begin
                r_pend     <= 1'b1;
                r_pendWe   <= w_liveWe;
                r_pendAddr <= systemAddr;
                r_pendData <= cpuDo;
            end else if (w_issuePend) begin
                r_pend     <= 1'b0;
            end

            if (w_bufClear) begin
                r_bufFull <= 1'b0;
            end else if (w_fill) begin
                r_bufFull <= 1'b1;
                r_bufAddr <= w_loadAddr;
                r_bufData <= ioctl_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbm2_ramctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbm2_ramctl
//  Purpose  : Self-checking bench for cbm2_ramctl. A behavioural memory with
//             programmable latency answers requests; expected transactions
//             and expected read data are queued when stimulus is driven and
//             compared as the design produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cbm2_ramctl;

    localparam int ADDR_W = 25;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              cpuCycle, vidCycle, cs_ram, systemWe;
    logic [ADDR_W-1:0] systemAddr;
    logic [7:0]        cpuDo;
    logic [7:0]        ramData;
    logic              ioctl_download, ioctl_wr, ioctl_wait;
    logic [23:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    always #5 clk_sys = ~clk_sys;

    cbm2_ramctl #(.ADDR_W(ADDR_W)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cpuCycle       (cpuCycle),
        .vidCycle       (vidCycle),
        .cs_ram         (cs_ram),
        .systemAddr     (systemAddr),
        .systemWe       (systemWe),
        .cpuDo          (cpuDo),
        .ramData        (ramData),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_ack        (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboards
    // ------------------------------------------------------------------
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } txn_t;

    txn_t       expQ[$];
    logic [7:0] rdQ[$];
    logic [7:0] expRam;

    // ------------------------------------------------------------------
    // Memory model: accepts a request, acks 'lat' clocks later
    // ------------------------------------------------------------------
    logic [7:0]        memArr [int];
    int                lat = 2;
    int                accepts = 0;
    bit                busy = 1'b0;
    int                busyCnt = 0;
    logic              modelAck = 1'b0;
    logic              strayAck = 1'b0;
    logic              curWe = 1'b0;
    logic [ADDR_W-1:0] curAddr = '0;
    logic [7:0]        curDin = 8'h00;

    assign mem_ack = modelAck | strayAck;

    initial mem_dout = 8'h00;

    always @(posedge clk_sys) begin
        modelAck <= 1'b0;
        if (busy) begin
            if (busyCnt == 0) begin
                modelAck <= 1'b1;
                busy     <= 1'b0;
                if (curWe) memArr[int'(curAddr)] = curDin;
                else mem_dout <= memArr.exists(int'(curAddr)) ? memArr[int'(curAddr)] : 8'h00;
            end else begin
                busyCnt <= busyCnt - 1;
            end
        end else if (mem_req && !modelAck) begin
            txn_t e;
            busy    <= 1'b1;
            busyCnt <= lat - 1;
            curWe   <= mem_we;
            curAddr <= mem_addr;
            curDin  <= mem_din;
            accepts++;
            if (expQ.size() == 0) begin
                checkValue("unexpectedReq", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkValue("reqWe", mem_we, e.we);
                checkValue("reqAddr", mem_addr, e.addr);
                if (e.we) checkValue("reqDin", mem_din, e.din);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    task automatic startCycle(input bit isCpu, input bit cs, input bit we,
                              input logic [ADDR_W-1:0] addr, input logic [7:0] d,
                              input logic [7:0] rdVal);
        cpuCycle   = isCpu;
        vidCycle   = !isCpu;
        cs_ram     = cs;
        systemWe   = we;
        systemAddr = addr;
        cpuDo      = d;
        if (cs) begin
            expQ.push_back('{we: isCpu & we, addr: addr, din: d});
            if (!(isCpu && we)) expRam = rdVal;
        end
        rdQ.push_back(expRam);
    endtask

    task automatic endCycle();
        cpuCycle = 1'b0;
        vidCycle = 1'b0;
        cs_ram   = 1'b0;
        systemWe = 1'b0;
        if (rdQ.size() != 0) checkValue("ramData", ramData, rdQ.pop_front());
        else checkValue("rdQueueEmpty", 1, 0);
        @(negedge clk_sys);
    endtask

    task automatic runCycle(input bit isCpu, input bit cs, input bit we,
                            input logic [ADDR_W-1:0] addr, input logic [7:0] d,
                            input logic [7:0] rdVal, input int len);
        startCycle(isCpu, cs, we, addr, d, rdVal);
        @(negedge clk_sys);
        checkValue("reqRise", mem_req, cs);
        repeat (len - 1) @(negedge clk_sys);
        endCycle();
    endtask

    task automatic waitNoStall();
        int n = 0;
        while (ioctl_wait && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) checkValue("stallTimeout", 1, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [7:0] dlData [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n;
        int acc0;
        reset_n = 1'b0;
        cpuCycle = 0; vidCycle = 0; cs_ram = 0; systemWe = 0;
        systemAddr = '0; cpuDo = 8'h00;
        ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_data = 8'h00;
        expRam = 8'h00;
        memArr[32'h0F1234] = 8'h5A;
        memArr[32'h002000] = 8'h3C;

        repeat (3) @(negedge clk_sys);
        checkValue("rstRamData", ramData, 8'h00);
        checkValue("rstReq", mem_req, 0);
        checkValue("rstWe", mem_we, 0);
        checkValue("rstAddr", mem_addr, 0);
        checkValue("rstDin", mem_din, 8'h00);
        checkValue("rstWait", ioctl_wait, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // CPU read, write, video read with systemWe, and a non-RAM cycle
        lat = 2;
        runCycle(1, 1, 0, 25'h0F1234, 8'h00, 8'h5A, 6);
        checkValue("oneReq", accepts, 1);
        runCycle(1, 1, 1, 25'h001000, 8'hA7, 8'h00, 6);
        runCycle(0, 1, 1, 25'h002000, 8'hFF, 8'h3C, 6);
        acc0 = accepts;
        runCycle(1, 0, 0, 25'h0F1234, 8'h00, 8'h00, 6);
        checkValue("noReqCs0", accepts, acc0);

        // Download of 4 bytes with slow memory; one extra strobe while
        // stalled must be dropped; download ends with a byte still buffered.
        lat = 5;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waitNoStall();
            ioctl_wr   = 1'b1;
            ioctl_addr = 24'(i);
            ioctl_data = dlData[i];
            expQ.push_back('{we: 1'b1, addr: 25'h0F0000 + 25'(i), din: dlData[i]});
            #1 checkValue("waitOnFill", ioctl_wait, 1);
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            if (i == 1) begin
                checkValue("waitBusy", ioctl_wait, 1);
                ioctl_wr   = 1'b1;
                ioctl_addr = 24'd9;
                ioctl_data = 8'hEE;
                @(negedge clk_sys);
                ioctl_wr = 1'b0;
            end
            if (i == 3) ioctl_download = 1'b0;
        end
        waitNoStall();
        repeat (2) @(negedge clk_sys);
        checkValue("dlCount", accepts, acc0 + 4);

        // Bus cycle starting while a load write is outstanding
        ioctl_download = 1'b1;
        ioctl_wr   = 1'b1;
        ioctl_addr = 24'd4;
        ioctl_data = 8'h99;
        expQ.push_back('{we: 1'b1, addr: 25'h0F0004, din: 8'h99});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk_sys); n++; end
        checkValue("loadStarted", mem_req & mem_we, 1);
        @(negedge clk_sys);
        startCycle(1, 1, 0, 25'h0F0004, 8'h00, 8'h99);
        n = 0;
        while (!mem_ack && n < 50) begin @(negedge clk_sys); n++; end
        checkValue("loadAckSeen", mem_ack, 1);
        @(negedge clk_sys);
        checkValue("pendReq", mem_req, 1);
        checkValue("pendAddr", mem_addr, 25'h0F0004);
        checkValue("pendWe", mem_we, 0);
        repeat (10) @(negedge clk_sys);
        endCycle();

        // Asynchronous reset during an outstanding read, then stray acks
        startCycle(1, 1, 0, 25'h001000, 8'h00, 8'hA7);
        void'(rdQ.pop_back());
        repeat (3) @(negedge clk_sys);
        checkValue("reqBeforeRst", mem_req, 1);
        #3 reset_n = 1'b0;
        #1;
        checkValue("arstReq", mem_req, 0);
        checkValue("arstAddr", mem_addr, 0);
        checkValue("arstRamData", ramData, 8'h00);
        checkValue("arstWait", ioctl_wait, 0);
        expRam = 8'h00;
        @(negedge clk_sys);
        cpuCycle = 0; cs_ram = 0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        acc0 = accepts;
        repeat (8) @(negedge clk_sys);
        strayAck = 1'b1;
        @(negedge clk_sys);
        strayAck = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkValue("strayReq", mem_req, 0);
        checkValue("strayRamData", ramData, 8'h00);
        checkValue("strayWait", ioctl_wait, 0);
        checkValue("strayAccepts", accepts, acc0);

        checkValue("sbEmpty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
